// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the shared ROM arbiter: request handshake plus broadcast response.
interface rom_arbiter_if #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned N_ADDR_BITS = 16
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ*(N_ADDR_BITS+1)-1:0] req_addr;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 resp_valid;
  logic [7:0]                         resp_data;
  logic                               resp_in_range;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data, resp_in_range
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data, resp_in_range
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin sharing of one synchronous-read puzzle ROM among NUM_REQ solver cores,
// with a one-cycle tag pipeline routing each response back to its requester.
module rom_arbiter #(
  parameter int unsigned N_ADDR_BITS = 16,
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rom_arbiter_if.slave         bus,
  output logic [N_ADDR_BITS:0] rom_addr,
  input  logic [7:0]           rom_data,
  input  logic                 rom_valid,
  output logic [CNT_WIDTH-1:0] grant_count
);
  localparam int unsigned AW  = N_ADDR_BITS + 1;
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] pend_id;
  logic           grant_any;
  logic           pend_v;
  int unsigned    idx;

  // Search from rr_ptr upward (wrapping); first requester found wins the ROM this cycle.
  always_comb begin
    grant_any     = 1'b0;
    grant_idx     = '0;
    ptr_nxt       = rr_ptr;
    idx           = 0;
    bus.req_ready = '0;
    rom_addr      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && !rst && bus.req_valid[IDW'(idx)]) begin
        grant_any                = 1'b1;
        grant_idx                = IDW'(idx);
        bus.req_ready[IDW'(idx)] = 1'b1;
        rom_addr                 = bus.req_addr[idx*AW +: AW];
        ptr_nxt                  = (idx + 1 >= NUM_REQ) ? '0 : IDW'(idx + 1);
      end
    end
  end

  // Pointer, response tag and saturating access counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      pend_v      <= 1'b0;
      pend_id     <= '0;
      grant_count <= '0;
    end else begin
      pend_v  <= grant_any;
      pend_id <= grant_idx;
      if (grant_any) rr_ptr <= ptr_nxt;
      if (grant_any && grant_count != '1) grant_count <= grant_count + CNT_WIDTH'(1);
    end
  end

  // ROM data arrives the cycle after the grant; steer it to the tagged owner.
  always_comb begin
    bus.resp_valid    = '0;
    bus.resp_data     = 8'h00;
    bus.resp_in_range = 1'b0;
    if (pend_v) begin
      bus.resp_valid[pend_id] = 1'b1;
      bus.resp_data           = rom_data;
      bus.resp_in_range       = rom_valid;
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench: vector table plus hand sequences, response scoreboard, behavioural ROM.
module tb_rom_arbiter;
  localparam logic [16:0] FILE_LEN = 17'd100;

  logic        clk;
  logic        rst;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_valid;
  logic [3:0]  grant_count;

  rom_arbiter_if #(.NUM_REQ(2), .N_ADDR_BITS(16)) bus ();

  rom_arbiter #(.N_ADDR_BITS(16), .NUM_REQ(2), .CNT_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rom_valid   (rom_valid),
    .grant_count (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [16:0] a);
    return (a[7:0] * 8'd3 + 8'h5A) ^ a[15:8];
  endfunction

  // Synchronous-read ROM: in-range flag low from FILE_LEN onward.
  always @(posedge clk) begin
    rom_data  <= rom_byte(rom_addr);
    rom_valid <= (rom_addr < FILE_LEN);
  end

  typedef struct {
    logic        r;
    logic [1:0]  v;
    logic [16:0] a0;
    logic [16:0] a1;
    logic [1:0]  er;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       inr;
  } rsp_t;

  vec_t       tbl[$];
  rsp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cnt = 4'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs 1ns later, update scoreboard/models.
  task automatic step(input logic r, input logic [1:0] v, input logic [16:0] a0,
                      input logic [16:0] a1, input logic [1:0] er);
    rsp_t        e;
    logic [1:0]  ev;
    logic [7:0]  ed;
    logic        ei;
    logic [16:0] ea;
    @(negedge clk);
    rst           = r;
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    #1;
    ev = 2'b00; ed = 8'h00; ei = 1'b0;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      ev = 2'(1 << e.id);
      ed = e.d;
      ei = e.inr;
    end
    chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
    chk("resp_data", 32'(bus.resp_data), 32'(ed));
    chk("resp_in_range", 32'(bus.resp_in_range), 32'(ei));
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    ea = (er == 2'b01) ? a0 : (er == 2'b10) ? a1 : 17'd0;
    chk("rom_addr", 32'(rom_addr), 32'(ea));
    chk("grant_count", 32'(grant_count), 32'(exp_cnt));
    if (er != 2'b00) begin
      e.id  = (er == 2'b01) ? 0 : 1;
      e.d   = rom_byte(ea);
      e.inr = (ea < FILE_LEN);
      sb.push_back(e);
      if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    end
    if (r) exp_cnt = 4'd0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_addr  = '0;
    repeat (2) @(posedge clk);

    // reset held with requests pending: no grants
    tbl.push_back('{1'b1, 2'b11, 17'd7,   17'd8,   2'b00});
    // lone requester, back-to-back addresses 0..4
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 2'b01, 17'(i), 17'd0, 2'b01});
    // contention, pointer now at 1
    tbl.push_back('{1'b0, 2'b11, 17'd10,  17'd20,  2'b10});
    tbl.push_back('{1'b0, 2'b11, 17'd10,  17'd20,  2'b01});
    tbl.push_back('{1'b0, 2'b11, 17'd10,  17'd20,  2'b10});
    tbl.push_back('{1'b0, 2'b11, 17'd10,  17'd20,  2'b01});
    // fairness: req1 alone, then both -> req0 then req1
    tbl.push_back('{1'b0, 2'b10, 17'd0,   17'd21,  2'b10});
    tbl.push_back('{1'b0, 2'b11, 17'd11,  17'd22,  2'b01});
    tbl.push_back('{1'b0, 2'b11, 17'd11,  17'd22,  2'b10});
    // end of file boundary, out-of-range still granted
    tbl.push_back('{1'b0, 2'b01, 17'd100, 17'd0,   2'b01});
    tbl.push_back('{1'b0, 2'b01, 17'd99,  17'd0,   2'b01});
    tbl.push_back('{1'b0, 2'b10, 17'd0,   17'd200, 2'b10});
    tbl.push_back('{1'b0, 2'b00, 17'd0,   17'd0,   2'b00});
    tbl.push_back('{1'b0, 2'b00, 17'd0,   17'd0,   2'b00});

    foreach (tbl[i]) step(tbl[i].r, tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].er);

    // reset mid-stream: grant req0 (ptr->1), then rst; ptr must return to 0
    step(1'b0, 2'b11, 17'd5, 17'd6, 2'b01);
    step(1'b1, 2'b11, 17'd5, 17'd6, 2'b00);
    step(1'b0, 2'b11, 17'd5, 17'd6, 2'b01);
    step(1'b0, 2'b11, 17'd5, 17'd6, 2'b10);

    // saturation: 20 more continuous grants on a 4-bit counter
    for (int k = 0; k < 20; k++)
      step(1'b0, 2'b11, 17'(30 + k), 17'(60 + k), (k % 2 == 0) ? 2'b01 : 2'b10);
    step(1'b0, 2'b00, 17'd0, 17'd0, 2'b00);
    chk("grant_count_saturated", 32'(grant_count), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
